// File: rtl/cla_mp_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
// The state encoding, slice width and the 4-bit lookahead cell live here.
package cla_mp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SLICE_W   = 16;
    localparam int unsigned MAX_WORDS = 8;
    localparam int unsigned IDX_W     = $clog2(MAX_WORDS);

    typedef struct packed {
        logic       p;
        logic       g;
        logic [3:0] c;
    } cla4_t;

    // 4-bit lookahead cell: carries into each bit plus group generate/propagate.
    function automatic cla4_t cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        cla4_t r;
        logic  t;
        r.p = &p;
        r.g = 1'b0;
        for (int j = 0; j < 4; j++) begin
            t = ci;
            for (int k = 0; k < j; k++) t = t & p[k];
            r.c[j] = t;
            for (int k = 0; k < j; k++) begin
                t = g[k];
                for (int m = k + 1; m < j; m++) t = t & p[m];
                r.c[j] = r.c[j] | t;
            end
        end
        for (int k = 0; k < 4; k++) begin
            t = g[k];
            for (int m = k + 1; m < 4; m++) t = t & p[m];
            r.g = r.g | t;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla16_slice.sv
// Combinational 16-bit carry-lookahead adder slice built from two levels
// of 4-bit lookahead cells; also exposes the carry into the MSB.
module cla16_slice
    import cla_mp_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c_msb
);

    localparam int unsigned GROUPS = SLICE_W / 4;

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] c;
    logic [GROUPS-1:0]  gg;
    logic [GROUPS-1:0]  gp;
    cla4_t              grp;
    cla4_t              top;

    always_comb begin
        g = a & b;
        p = a ^ b;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int i = 0; i < int'(GROUPS); i++) begin
            grp   = cla4(g[4*i +: 4], p[4*i +: 4], 1'b0);
            gg[i] = grp.g;
            gp[i] = grp.p;
        end
        // Second level resolves group carry-ins, then each group fans out its bit carries.
        top = cla4(gg, gp, cin);
        for (int i = 0; i < int'(GROUPS); i++) begin
            grp          = cla4(g[4*i +: 4], p[4*i +: 4], top.c[i]);
            c[4*i +: 4]  = grp.c;
        end
        s     = p ^ c;
        cout  = top.g | (top.p & cin);
        c_msb = c[SLICE_W-1];
    end

endmodule

// File: rtl/cla_mp_sequencer.sv
// Multi-precision adder: one 16-bit CLA slice reused LSW first, one word per cycle.
// Define CLA_MP_SUB_EN to enable subtraction via the sub request.
module cla_mp_sequencer
    import cla_mp_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORDS*SLICE_W-1:0]   a,
    input  logic [WORDS*SLICE_W-1:0]   b,
    input  logic                       cin,
    input  logic                       sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDS*SLICE_W-1:0]   sum,
    output logic                       cout,
    output logic                       ovf,
    output logic                       busy
);

    localparam int unsigned TOTAL_W = WORDS * SLICE_W;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic [TOTAL_W-1:0]   a_r;
    logic [TOTAL_W-1:0]   b_r;
    logic                 accept;
    logic                 last;
    logic                 init_carry;
    logic [SLICE_W-1:0]   slice_a;
    logic [SLICE_W-1:0]   b_word;
    logic [SLICE_W-1:0]   slice_b;
    logic [SLICE_W-1:0]   slice_s;
    logic                 slice_cout;
    logic                 slice_cmsb;

`ifdef CLA_MP_SUB_EN
    logic sub_r;
    assign init_carry = sub ? 1'b1 : cin;
    assign slice_b    = b_word ^ {SLICE_W{sub_r}};
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign init_carry = cin;
    assign slice_b    = b_word;
`endif

    // Word select for the current index.
    always_comb begin
        slice_a = '0;
        b_word  = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (idx == IDX_W'(i)) begin
                slice_a = a_r[i*SLICE_W +: SLICE_W];
                b_word  = b_r[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla16_slice u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = (idx == IDX_W'(WORDS - 1));
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef CLA_MP_SUB_EN
            sub_r     <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == DONE);
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                idx   <= '0;
                carry <= init_carry;
                sum   <= '0;
`ifdef CLA_MP_SUB_EN
                sub_r <= sub;
`endif
            end else if (state == RUN) begin
                for (int i = 0; i < int'(WORDS); i++) begin
                    if (idx == IDX_W'(i)) sum[i*SLICE_W +: SLICE_W] <= slice_s;
                end
                carry <= slice_cout;
                if (last) begin
                    cout <= slice_cout;
                    ovf  <= slice_cmsb ^ slice_cout;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Self-checking bench for cla_mp_sequencer (WORDS=4): directed cases plus
// random operands compared against a full-width arithmetic reference.
module tb_cla_mp_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned TW    = WORDS * 16;
`ifdef CLA_MP_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct {
        logic [TW-1:0] s;
        logic          co;
        logic          ov;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] a = '0;
    logic [TW-1:0] b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] sum;
    logic          cout;
    logic          ovf;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [TW-1:0] s, input logic co, input logic ov);
        res_t r;
        r.s  = s;
        r.co = co;
        r.ov = ov;
        return r;
    endfunction

    // Whole-operand reference: plain wide addition, signed overflow from operand signs.
    function automatic res_t model(input logic [TW-1:0] x, input logic [TW-1:0] y,
                                   input logic ci, input logic su);
        logic [TW:0]   full;
        logic [TW-1:0] yy;
        logic          c0;
        res_t          r;
        yy = y;
        c0 = ci;
        if (SUB_EN && su) begin
            yy = ~y;
            c0 = 1'b1;
        end
        full = {1'b0, x} + {1'b0, yy} + (TW+1)'(c0);
        r.s  = full[TW-1:0];
        r.co = full[TW];
        r.ov = (x[TW-1] == yy[TW-1]) && (full[TW-1] != x[TW-1]);
        return r;
    endfunction

    // Present operands; returns at the falling edge right after the acceptance edge.
    task automatic start_op(input logic [TW-1:0] x, input logic [TW-1:0] y,
                            input logic ci, input logic su);
        @(negedge clk);
        a = x; b = y; cin = ci; sub = su;
        in_valid = 1'b1;
        check("in_ready_idle", TW'(in_ready), TW'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_run", TW'(in_ready), TW'(0));
        check("busy_run", TW'(busy), TW'(1));
    endtask

    task automatic wait_result(input string tag, input res_t e);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, TW'(lat), TW'(WORDS));
        check({tag, "_sum"}, sum, e.s);
        check({tag, "_cout"}, TW'(cout), TW'(e.co));
        check({tag, "_ovf"}, TW'(ovf), TW'(e.ov));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, TW'(out_valid), TW'(0));
        check({tag, "_ready_back"}, TW'(in_ready), TW'(1));
        check({tag, "_busy_drop"}, TW'(busy), TW'(0));
    endtask

    initial begin
        res_t e1;
        res_t e2;
        logic [TW-1:0] rx;
        logic [TW-1:0] ry;
        logic rc;
        logic rs;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", TW'(in_ready), TW'(1));
        check("rst_out_valid", TW'(out_valid), TW'(0));
        check("rst_busy", TW'(busy), TW'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", TW'(cout), TW'(0));
        check("rst_ovf", TW'(ovf), TW'(0));
        rst_n = 1'b1;

        // Carry out of the first word only
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        wait_result("word_carry", mk(64'h0000_0000_0001_0000, 1'b0, 1'b0));
        handoff("word_carry");

        // Carry ripples through every word
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_result("full_ripple", mk(64'h0, 1'b1, 1'b0));
        handoff("full_ripple");

        // Signed overflow via carry-in
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        wait_result("signed_ovf", mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
        handoff("signed_ovf");

        // Subtract request
        if (SUB_EN) e1 = mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        else        e1 = mk(64'hC, 1'b0, 1'b0);
        start_op(64'h5, 64'h7, 1'b0, 1'b1);
        wait_result("sub_req", e1);
        handoff("sub_req");

        // Backpressure with a second request held pending
        e1 = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        e2 = model(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1, 1'b0);
        start_op(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        wait_result("bp_first", e1);
        a = 64'h8000_0000_0000_0001; b = 64'h8000_0000_0000_0002; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_hold", TW'(out_valid), TW'(1));
            check("bp_sum_hold", sum, e1.s);
            check("bp_no_accept", TW'(in_ready), TW'(0));
        end
        handoff("bp_release");
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_busy", TW'(busy), TW'(1));
        wait_result("bp_second", e2);
        handoff("bp_second");

        // Reset during the second RUN cycle abandons the operation
        start_op(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_rst_valid", TW'(out_valid), TW'(0));
        check("midrun_rst_sum", sum, '0);
        check("midrun_rst_busy", TW'(busy), TW'(0));
        check("midrun_rst_ready", TW'(in_ready), TW'(1));
        repeat (WORDS + 1) @(negedge clk);
        check("midrun_no_stale", TW'(out_valid), TW'(0));
        start_op(64'h1234, 64'h4321, 1'b0, 1'b0);
        wait_result("after_rst", mk(64'h5555, 1'b0, 1'b0));
        handoff("after_rst");

        // Random operands with random result hand-off delay
        for (int n = 0; n < 24; n++) begin
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if (n % 6 == 0) ry = ~rx;
            e1 = model(rx, ry, rc, rs);
            start_op(rx, ry, rc, rs);
            wait_result("rand", e1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rand_hold", sum, e1.s);
            end
            handoff("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
